// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
// The arbiter sits on the slave side. The bench, or the requesters plus memory, sit on the master side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch port
  logic              i_f_req;
  logic [ADDR_W-1:0] i_f_addr;
  logic              o_f_gnt;
  logic              o_f_rvalid;
  logic [DATA_W-1:0] o_f_rdata;

  // data port
  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic              o_d_gnt;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;
  logic              o_d_err;

  // single-port memory side
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_data_write;
  logic              o_mem_write_en;
  logic [DATA_W-1:0] i_mem_data;

  modport slave (
    input  i_f_req, i_f_addr,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
    input  i_mem_data,
    output o_f_gnt, o_f_rvalid, o_f_rdata,
    output o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
    output o_mem_addr, o_mem_data_write, o_mem_write_en
  );

  modport master (
    output i_f_req, i_f_addr,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata,
    output i_mem_data,
    input  o_f_gnt, o_f_rvalid, o_f_rdata,
    input  o_d_gnt, o_d_rvalid, o_d_rdata, o_d_err,
    input  o_mem_addr, o_mem_data_write, o_mem_write_en
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch + data) arbiter in front of a single-port memory.
// The data port has priority. A fetch request that keeps losing is forced through after
// STARVE_MAX consecutive lost cycles. Read data comes back one cycle after the grant.
// The owner of that return is held in a small tag register.
//
// tag state | meaning
// ----------+---------------------------------------------
// TAG_NONE  | no read in flight, both rvalid low
// TAG_FETCH | fetch read granted last cycle, o_f_rvalid now
// TAG_DATA  | data read granted last cycle, o_d_rvalid now
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2
  } tag_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  tag_t              tag;
  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] addr_q;

  logic f_win;
  logic d_win;
  logic d_misaligned;
  logic wr_en;

  // Grants are combinational from the requests and the registered starve count. They are gated while reset is held.
  assign d_misaligned = (bus.i_d_addr[1:0] != 2'b00);
  assign f_win = !i_reset && bus.i_f_req && (!bus.i_d_req || (starve_cnt == STARVE_LIM));
  assign d_win = !i_reset && bus.i_d_req && !f_win;
  assign wr_en = d_win && bus.i_d_we && !d_misaligned;

  assign bus.o_f_gnt          = f_win;
  assign bus.o_d_gnt          = d_win;
  assign bus.o_d_err          = d_win && d_misaligned;
  assign bus.o_mem_write_en   = wr_en;
  assign bus.o_mem_data_write = wr_en ? bus.i_d_wdata : '0;
  assign bus.o_mem_addr       = f_win ? bus.i_f_addr : (d_win ? bus.i_d_addr : addr_q);

  assign bus.o_f_rvalid = (tag == TAG_FETCH);
  assign bus.o_d_rvalid = (tag == TAG_DATA);
  assign bus.o_f_rdata  = (tag == TAG_FETCH) ? bus.i_mem_data : '0;
  assign bus.o_d_rdata  = (tag == TAG_DATA)  ? bus.i_mem_data : '0;

  // Count consecutive cycles the fetch port asks and loses, saturating at the limit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      starve_cnt <= 4'd0;
    end else if (f_win || !bus.i_f_req) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Remember the last granted address so the memory address holds steady through idle cycles.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_q <= '0;
    end else if (f_win) begin
      addr_q <= bus.i_f_addr;
    end else if (d_win) begin
      addr_q <= bus.i_d_addr;
    end
  end

  // Record which port owns next cycle's read data. Writes and rejected accesses return nothing.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tag <= TAG_NONE;
    end else if (f_win) begin
      tag <= TAG_FETCH;
    end else if (d_win && !bus.i_d_we && !d_misaligned) begin
      tag <= TAG_DATA;
    end else begin
      tag <= TAG_NONE;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, 32, data word width.
REQ-003 SHALL have parameter STARVE_MAX, 3, consecutive fetch-losing cycles before fetch is forced to win; legal range 1..15.
REQ-004 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port i_reset  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port i_f_req  input  1  fetch port read request.
REQ-007 SHALL have port i_f_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have port o_f_gnt  output  1  fetch request accepted this cycle.
REQ-009 SHALL have port o_f_rvalid  output  1  fetch read data valid.
REQ-010 SHALL have port o_f_rdata  output  DATA_W  fetch read data.
REQ-011 SHALL have port i_d_req  input  1  data port request.
REQ-012 SHALL have port i_d_we  input  1  data port write (1) or read (0).
REQ-013 SHALL have port i_d_addr  input  ADDR_W  data address.
REQ-014 SHALL have port i_d_wdata  input  DATA_W  data write value.
REQ-015 SHALL have port o_d_gnt  output  1  data request accepted this cycle.
REQ-016 SHALL have port o_d_rvalid  output  1  data read data valid.
REQ-017 SHALL have port o_d_rdata  output  DATA_W  data read data.
REQ-018 SHALL have port o_d_err  output  1  misaligned data access rejected (one-cycle pulse).
REQ-019 SHALL have port o_mem_addr  output  ADDR_W  to memory address.
REQ-020 SHALL have port o_mem_data_write  output  DATA_W  to memory write data.
REQ-021 SHALL have port o_mem_write_en  output  1  to memory write strobe.
REQ-022 SHALL have port i_mem_data  input  DATA_W  memory read data, valid one cycle after address.

Function
REQ-023 Memory SHALL be single-port; at most one of o_f_gnt, o_d_gnt high per cycle.
REQ-024 Handshake: request accepted in cycle where req && gnt; requester SHALL hold req, addr, we, wdata stable until gnt; gnt is combinational from req and registered arbitration state.
REQ-025 Arbitration: data port wins conflicts unless starve counter == STARVE_MAX, then fetch wins.
REQ-026 Starve counter (4 bits): increments when i_f_req && !o_f_gnt; clears to 0 on o_f_gnt or !i_f_req; saturates at STARVE_MAX.
REQ-027 Granted access drives o_mem_addr = granted addr combinationally in grant cycle; with no grant o_mem_addr holds last registered granted address.
REQ-028 Data write: o_mem_write_en = 1 and o_mem_data_write = i_d_wdata in grant cycle only; no rvalid generated.
REQ-029 Reads: o_x_rvalid = 1 exactly one cycle after grant, o_x_rdata = i_mem_data in that cycle; tag register records owner.
REQ-030 Throughput SHALL be one access per cycle; back-to-back grants to either port with no bubble.
REQ-031 Misaligned data access (i_d_addr[1:0] != 0): o_d_gnt = 1, o_d_err = 1 same cycle, o_mem_write_en = 0, no rvalid; counts as a data win for arbitration.
REQ-032 Fetch addresses are not alignment-checked; low two bits passed through.
REQ-033 o_f_rdata / o_d_rdata SHALL be 0 when respective rvalid is 0.

Reset
REQ-034 While i_reset = 1: o_f_gnt, o_d_gnt, o_f_rvalid, o_d_rvalid, o_d_err, o_mem_write_en = 0; o_mem_addr = 0; starve counter = 0; tag cleared.
REQ-035 Reset asserted the cycle after a read grant SHALL suppress that rvalid; no rvalid after reset deasserts.
REQ-036 First grant possible in first cycle with i_reset = 0.

Verification
REQ-037 Fetch only, addr 0x0,0x4,0x8 back-to-back -> o_f_gnt three cycles, o_f_rvalid cycles 2-4 with memory words in order.
REQ-038 Both requesting continuously, STARVE_MAX=3 -> grant pattern D,D,D,F repeating; never both gnt.
REQ-039 Data write addr 0x10 wdata 0xDEADBEEF then data read 0x10 -> write_en one cycle, read returns 0xDEADBEEF on o_d_rvalid.
REQ-040 Data read addr 0x13 -> o_d_err one cycle, o_mem_write_en 0, no o_d_rvalid.
REQ-041 Fetch grant then i_reset asserted next cycle -> o_f_rvalid stays 0; all outputs 0 during reset.
REQ-042 Fetch requests alone for 5 cycles with no data request -> counter stays 0, fetch granted every cycle.
